// File: rtl/sync_normalizer.sv
// sync_normalizer: polarity-normalized sync with leading-edge strobe, period/width measurement and lock flag.
// Define SYNC_NORMALIZER_WIDTH_EN to build the pulse width counter; otherwise width_out is tied to 0.
module sync_normalizer #(
  parameter int PERIOD_W   = 16,
  parameter int TOL        = 8,
  parameter int LOCK_COUNT = 4
) (
  input  logic                clk_50mhz_in,
  input  logic                reset_n,
  input  logic                sync_in,
  input  logic                positive_polarity_in,
  output logic                sync_out,
  output logic                sync_rise_out,
  output logic [PERIOD_W-1:0] period_out,
  output logic [PERIOD_W-1:0] width_out,
  output logic                locked_out
);
  typedef enum logic [1:0] {UNLOCKED, TRACKING, LOCKED} state_t;
  state_t              state_q, state_d;
  logic                s1_q, s2_q, pol_q, pold_q, init_q, norm_q, rise_q;
  logic                pvalid_q, pvalid_d;
  logic [3:0]          match_q, match_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d, period_q, period_d;
  logic                norm, prime, rise, sat, near;
  logic [PERIOD_W:0]   diff;
  assign norm  = pol_q ? s2_q : ~s2_q;
  // Prime on the first cycle out of reset and whenever the registered polarity has just changed.
  assign prime = ~init_q | (pol_q ^ pold_q);
  assign rise  = norm & ~norm_q & ~prime;
  assign sat   = &cnt_q;
  assign diff  = ({1'b0, cnt_q} >= {1'b0, period_q}) ? {1'b0, cnt_q} - {1'b0, period_q}
                                                     : {1'b0, period_q} - {1'b0, cnt_q};
  assign near  = diff <= (PERIOD_W+1)'(TOL);
  always_comb begin
    state_d  = state_q;
    pvalid_d = pvalid_q;
    match_d  = match_q;
    period_d = period_q;
    cnt_d    = prime ? '0 : rise ? PERIOD_W'(1) : sat ? cnt_q : cnt_q + 1'b1;
    if (rise) begin
      if (state_q == UNLOCKED) begin
        state_d  = TRACKING;
        pvalid_d = 1'b0;
      end else begin
        period_d = cnt_q;
        if (state_q == TRACKING && !pvalid_q) begin
          pvalid_d = 1'b1;
          match_d  = '0;
        end else if (near) begin
          if (state_q == TRACKING) begin
            match_d = match_q + 4'd1;
            state_d = (match_d == 4'(LOCK_COUNT)) ? LOCKED : TRACKING;
          end
        end else begin
          match_d = '0;
          state_d = TRACKING;
        end
      end
    end
    if (prime | sat) begin
      state_d = UNLOCKED;
      match_d = '0;
    end
  end
  always_ff @(posedge clk_50mhz_in or negedge reset_n) begin
    if (!reset_n) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      pol_q    <= 1'b0;
      pold_q   <= 1'b0;
      init_q   <= 1'b0;
      norm_q   <= 1'b0;
      rise_q   <= 1'b0;
      state_q  <= UNLOCKED;
      pvalid_q <= 1'b0;
      match_q  <= '0;
      cnt_q    <= '0;
      period_q <= '0;
    end else begin
      s1_q     <= sync_in;
      s2_q     <= s1_q;
      pol_q    <= positive_polarity_in;
      pold_q   <= pol_q;
      init_q   <= 1'b1;
      norm_q   <= norm;
      rise_q   <= rise;
      state_q  <= state_d;
      pvalid_q <= pvalid_d;
      match_q  <= match_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
    end
  end
`ifdef SYNC_NORMALIZER_WIDTH_EN
  logic [PERIOD_W-1:0] wcnt_q, width_q;
  logic                fall;
  assign fall = ~norm & norm_q & ~prime;
  // A trailing edge with no measured leading edge (e.g. the settle pulse after prime) is not a pulse.
  always_ff @(posedge clk_50mhz_in or negedge reset_n) begin
    if (!reset_n) begin
      wcnt_q  <= '0;
      width_q <= '0;
    end else begin
      wcnt_q <= (prime | rise) ? '0 : (norm & ~&wcnt_q) ? wcnt_q + 1'b1 : wcnt_q;
      if (fall && state_q != UNLOCKED) width_q <= (&wcnt_q) ? wcnt_q : wcnt_q + 1'b1;
    end
  end
  assign width_out = width_q;
`else
  assign width_out = '0;
`endif
  assign sync_out      = norm_q;
  assign sync_rise_out = rise_q;
  assign period_out    = period_q;
  assign locked_out    = (state_q == LOCKED);
endmodule

// File: tb/tb_sync_normalizer.sv
// tb_sync_normalizer: directed checks of sync normalization, period/width measurement, lock and saturation.
module tb_sync_normalizer;
  logic        clk = 1'b0, reset_n = 1'b0, sync_in = 1'b1, pol = 1'b0;
  logic        sync_out, sync_rise_out, locked_out;
  logic [15:0] period_out, width_out;
  int          passes = 0, checks = 0, fails = 0;
  logic        act = 1'b0;
  logic        rise_at, lock_at, pre_at, bad;
  logic [15:0] per_at;
  int          hi_cnt;
  int          jl[6] = '{328, 320, 312, 320, 328, 320};
`ifdef SYNC_NORMALIZER_WIDTH_EN
  localparam int WEXP = 35;
`else
  localparam int WEXP = 0;
`endif

  sync_normalizer dut (
    .clk_50mhz_in(clk), .reset_n(reset_n), .sync_in(sync_in),
    .positive_polarity_in(pol), .sync_out(sync_out), .sync_rise_out(sync_rise_out),
    .period_out(period_out), .width_out(width_out), .locked_out(locked_out)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  // One line of length per with an active pulse of w clocks; samples around the expected strobe.
  task automatic line(input int per, input int w);
    hi_cnt = 0;
    for (int i = 0; i < per; i++) begin
      sync_in = (i < w) ? act : ~act;
      tick;
      if (sync_out) hi_cnt++;
      if (i == 1) pre_at = sync_out;
      if (i == 2) begin
        rise_at = sync_rise_out;
        lock_at = locked_out;
        per_at  = period_out;
      end
    end
  endtask

  initial begin
    tick;
    repeat (6) begin
      sync_in = ~sync_in;
      tick;
    end
    chk("rst_sync_out", sync_out, 0);
    chk("rst_rise", sync_rise_out, 0);
    chk("rst_period", period_out, 0);
    chk("rst_width", width_out, 0);
    chk("rst_locked", locked_out, 0);
    reset_n = 1'b1;
    sync_in = 1'b1;
    bad = 1'b0;
    repeat (10) begin
      tick;
      bad |= sync_rise_out;
    end
    chk("no_rise_after_reset", bad, 0);
    for (int k = 1; k <= 6; k++) begin
      line(320, 35);
      if (k == 1) begin
        chk("latency_pre", pre_at, 0);
        chk("latency_rise", rise_at, 1);
      end
      if (k == 2) chk("period_first", per_at, 320);
      if (k == 5) chk("lock_edge5", lock_at, 0);
      if (k == 6) begin
        chk("lock_edge6", lock_at, 1);
        chk("pulse_width_neg", hi_cnt, 35);
        chk("width_out_neg", width_out, WEXP);
      end
    end
    line(320, 35);
    line(330, 35);
    chk("lock_before_bad", lock_at, 1);
    line(320, 35);
    chk("bad_unlock", lock_at, 0);
    chk("bad_period", per_at, 330);
    for (int k = 1; k <= 5; k++) begin
      line(320, 35);
      if (k == 1) chk("after_bad_mismatch", lock_at, 0);
      if (k == 4) chk("relock_pending", lock_at, 0);
      if (k == 5) chk("relock", lock_at, 1);
    end
    foreach (jl[j]) begin
      line(jl[j], 35);
      chk("jitter_lock", lock_at, 1);
    end
    pol = 1'b1;
    act = 1'b1;
    sync_in = 1'b0;
    bad = 1'b0;
    tick;
    bad |= sync_rise_out;
    tick;
    bad |= sync_rise_out;
    chk("flip_unlock", locked_out, 0);
    repeat (18) begin
      tick;
      bad |= sync_rise_out;
    end
    chk("flip_no_rise", bad, 0);
    for (int k = 1; k <= 6; k++) begin
      line(320, 35);
      if (k == 1) chk("pos_rise", rise_at, 1);
      if (k == 2) chk("pos_period", per_at, 320);
      if (k == 5) chk("pos_lock5", lock_at, 0);
      if (k == 6) begin
        chk("pos_lock6", lock_at, 1);
        chk("pulse_width_pos", hi_cnt, 35);
        chk("width_out_pos", width_out, WEXP);
      end
    end
    line(320, 35);
    repeat (65537 - 320) tick;
    chk("sat_still_locked", locked_out, 1);
    tick;
    chk("sat_unlock", locked_out, 0);
    chk("sat_period_hold", period_out, 320);
    sync_in = act;
    repeat (10) tick;
    chk("mid_pulse_high", sync_out, 1);
    #3 reset_n = 1'b0;
    #1;
    chk("async_sync_out", sync_out, 0);
    chk("async_period", period_out, 0);
    chk("async_width", width_out, 0);
    chk("async_locked", locked_out, 0);
    tick;
    reset_n = 1'b1;
    tick;
    chk("rerelease_rise", sync_rise_out, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
